// File: rtl/banked_memory.sv
// Banked byte memory between the Z8 core and on-chip block RAM: one synchronous
// RAM/ROM per bank, strobe/ready handshake, registered output mux, zero-fill after reset.
module banked_memory #(
  parameter int unsigned           BANK_ADDR_WIDTH = 11,
  parameter int unsigned           BANK_COUNT      = 4,
  parameter logic [BANK_COUNT-1:0] ROM_BANK_MASK   = '0,
  parameter bit                    CLEAR_ON_RESET  = 1'b1,
  localparam int unsigned          ADDR_WIDTH      = BANK_ADDR_WIDTH + $clog2(BANK_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            dataIn,
  output logic [7:0]            dataOut,
  input  logic                  write,
  input  logic                  strobe,
  output logic                  ready,
  output logic                  valid,
  output logic                  writeFault,
  output logic                  busy
);

  localparam int unsigned BANK_DEPTH = 2 ** BANK_ADDR_WIDTH;
  localparam int unsigned SEL_WIDTH  = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e                     state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [SEL_WIDTH-1:0]       bank_sel_q, bank_sel_d;
  logic                       valid_q, valid_d;
  logic                       fault_q, fault_d;

  logic [SEL_WIDTH-1:0]       bank_idx;
  logic [BANK_ADDR_WIDTH-1:0] offset;
  logic                       accept;
  logic                       clearing;
  logic [7:0]                 bank_rdata [BANK_COUNT];

  // Full decode: the bits above the bank offset always name exactly one bank.
  assign bank_idx = SEL_WIDTH'(addr >> BANK_ADDR_WIDTH);
  assign offset   = addr[BANK_ADDR_WIDTH-1:0];

  // Reset wins over a simultaneous strobe, so the access is simply never accepted.
  assign accept   = (state_q == ST_IDLE) && strobe && !reset;
  assign clearing = (state_q == ST_CLEAR) && !reset;

  // NOTE: every variable is given a default before any branch so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    bank_sel_d = bank_sel_q;
    valid_d    = accept;
    fault_d    = accept && write && ROM_BANK_MASK[bank_idx];
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) bank_sel_d = bank_idx;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_IDLE;
      clr_cnt_q  <= '0;
      bank_sel_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      bank_sel_q <= bank_sel_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    localparam bit IS_ROM = ROM_BANK_MASK[b];

    logic [7:0]                 mem_q [BANK_DEPTH];
    logic [7:0]                 rdata_q;
    logic                       sel;
    logic                       mem_we;
    logic [BANK_ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]                 mem_wdata;

    assign sel = accept && (bank_idx == SEL_WIDTH'(b));

    // The fill and normal writes share the single write port of each RAM bank.
    always_comb begin
      mem_we    = 1'b0;
      mem_addr  = offset;
      mem_wdata = dataIn;
      if (!IS_ROM) begin
        if (clearing) begin
          mem_we    = 1'b1;
          mem_addr  = clr_cnt_q;
          mem_wdata = '0;
        end else if (sel && write) begin
          mem_we = 1'b1;
        end
      end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    // A refused ROM write still returns the stored byte, like a read.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q <= '0;
      end else if (sel) begin
        rdata_q <= (write && !IS_ROM) ? dataIn : mem_q[offset];
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  assign dataOut    = bank_rdata[bank_sel_q];
  assign ready      = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_CLEAR) || (reset && CLEAR_ON_RESET);
  assign valid      = valid_q;
  assign writeFault = fault_q;

endmodule

// File: tb/tb_banked_memory.sv
// Bench for banked_memory: a 4-bank zero-filled RAM instance and a 2-bank instance
// with bank 0 read-only and no fill, both checked against flat byte-array models.
module tb_banked_memory;

  localparam int AW_A = 13;
  localparam int AW_B = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_reset, a_write, a_strobe, a_ready, a_valid, a_fault, a_busy;
  logic [AW_A-1:0] a_addr;
  logic [7:0]      a_din, a_dout;
  logic            b_reset, b_write, b_strobe, b_ready, b_valid, b_fault, b_busy;
  logic [AW_B-1:0] b_addr;
  logic [7:0]      b_din, b_dout;

  banked_memory #(
    .BANK_ADDR_WIDTH(11), .BANK_COUNT(4), .ROM_BANK_MASK(4'b0000), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .reset(a_reset), .addr(a_addr), .dataIn(a_din), .dataOut(a_dout),
    .write(a_write), .strobe(a_strobe), .ready(a_ready), .valid(a_valid),
    .writeFault(a_fault), .busy(a_busy)
  );

  banked_memory #(
    .BANK_ADDR_WIDTH(11), .BANK_COUNT(2), .ROM_BANK_MASK(2'b01), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .reset(b_reset), .addr(b_addr), .dataIn(b_din), .dataOut(b_dout),
    .write(b_write), .strobe(b_strobe), .ready(b_ready), .valid(b_valid),
    .writeFault(b_fault), .busy(b_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference contents: one flat byte array per instance, indexed by the full address.
  logic [7:0] model_a [1 << AW_A];
  logic [7:0] model_b [1 << AW_B];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad_fill1, bad_fill2, ready_cycle;
    bad_fill1   = 0;
    bad_fill2   = 0;
    ready_cycle = 0;
    a_reset = 1'b1; a_strobe = 1'b1; a_write = 1'b1; a_addr = 13'h0123; a_din = 8'hEE;
    tick();
    vectors++;
    if ({a_busy, a_ready, a_valid, a_fault} !== 4'b1000 || a_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got busy/ready/valid/fault=%b data=%02h, want 1000 data=00",
               {a_busy, a_ready, a_valid, a_fault}, a_dout);
    end
    tick();
    a_reset = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      a_addr = AW_A'($urandom);
      tick();
      if (a_ready !== 1'b0 || a_busy !== 1'b1 || a_valid !== 1'b0 || a_fault !== 1'b0) bad_fill1++;
    end
    vectors++;
    if (bad_fill1 != 0) begin
      miscompares++;
      $display("FAIL fill_first_1000: got %0d bad cycles, want 0", bad_fill1);
    end
    a_reset = 1'b1;
    tick();
    vectors++;
    if ({a_busy, a_ready, a_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL midfill_reset: got busy/ready/valid=%b, want 100", {a_busy, a_ready, a_valid});
    end
    a_reset = 1'b0;
    a_strobe = 1'b0;
    for (int c = 1; c <= 2100 && ready_cycle == 0; c++) begin
      // Late in the fill, strobe writes at offsets already cleared; they must not land.
      a_strobe = (c > 20);
      a_write  = 1'b1;
      a_din    = 8'hFF;
      a_addr   = {2'($urandom), 11'(c - 20)};
      tick();
      if (a_valid !== 1'b0 || a_fault !== 1'b0) bad_fill2++;
      if (a_ready === 1'b1) ready_cycle = c;
      else if (a_busy !== 1'b1) bad_fill2++;
    end
    a_strobe = 1'b0;
    vectors++;
    if (ready_cycle != 2048) begin
      miscompares++;
      $display("FAIL fill_length: got ready after %0d cycles, want 2048", ready_cycle);
    end
    vectors++;
    if (bad_fill2 != 0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_status: got %0d bad cycles busy_end=%b, want 0 busy_end=0", bad_fill2, a_busy);
    end
    for (int i = 0; i < (1 << AW_A); i++) model_a[i] = 8'h00;
  endtask

  task automatic test_read_zero;
    a_strobe = 1'b1; a_write = 1'b0; a_addr = 13'h01A5;
    tick();
    vectors++;
    if (a_valid !== 1'b1 || a_fault !== 1'b0 || a_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL read_after_fill: got valid=%b fault=%b data=%02h, want 1 0 00", a_valid, a_fault, a_dout);
    end
    a_strobe = 1'b0;
    tick();
    vectors++;
    if (a_valid !== 1'b0 || a_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL valid_single_pulse: got valid=%b data=%02h, want 0 00", a_valid, a_dout);
    end
  endtask

  task automatic test_write_read;
    logic [AW_A-1:0] ads [3];
    logic            wrs [3];
    logic [7:0]      exps [3];
    ads  = '{13'h0803, 13'h0803, 13'h0003};
    wrs  = '{1'b1, 1'b0, 1'b0};
    exps = '{8'h5C, 8'h5C, 8'h00};
    for (int i = 0; i < 3; i++) begin
      a_strobe = 1'b1; a_write = wrs[i]; a_addr = ads[i]; a_din = 8'h5C;
      tick();
      vectors++;
      if (a_valid !== 1'b1 || a_fault !== 1'b0 || a_dout !== exps[i]) begin
        miscompares++;
        $display("FAIL write_read[%0d] addr=%h: got valid=%b fault=%b data=%02h, want 1 0 %02h",
                 i, ads[i], a_valid, a_fault, a_dout, exps[i]);
      end
    end
    a_strobe = 1'b0;
    model_a[13'h0803] = 8'h5C;
  endtask

  task automatic test_back_to_back;
    logic [AW_A-1:0] ads [3];
    logic [7:0]      vals [3];
    ads  = '{13'h0000, 13'h1800, 13'h0800};
    vals = '{8'h11, 8'h44, 8'h22};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        a_strobe = 1'b1; a_write = (pass == 0); a_addr = ads[i]; a_din = vals[i];
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_dout !== vals[i]) begin
          miscompares++;
          $display("FAIL back_to_back[%0d][%0d]: got valid=%b data=%02h, want 1 %02h",
                   pass, i, a_valid, a_dout, vals[i]);
        end
        model_a[ads[i]] = vals[i];
      end
    end
    a_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_addr = AW_A'($urandom);
      a_write = 1'($urandom);
      tick();
      vectors++;
      if (a_valid !== 1'b0 || a_dout !== 8'h22) begin
        miscompares++;
        $display("FAIL hold_on_addr_change[%0d]: got valid=%b data=%02h, want 0 22", i, a_valid, a_dout);
      end
    end
  endtask

  task automatic test_random_a;
    logic [AW_A-1:0] ad;
    logic [7:0]      d, exp_d;
    logic            st, wr;
    exp_d = 8'h22;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom);
      ad = ($urandom_range(0, 1) == 1) ? AW_A'($urandom) : {2'($urandom), 7'd0, 4'($urandom)};
      d  = 8'($urandom);
      a_strobe = st; a_write = wr; a_addr = ad; a_din = d;
      tick();
      if (st) begin
        if (wr) model_a[ad] = d;
        exp_d = model_a[ad];
      end
      vectors++;
      if (a_valid !== st || a_fault !== 1'b0 || a_dout !== exp_d) begin
        miscompares++;
        $display("FAIL random_a[%0d] addr=%h st=%b wr=%b: got valid=%b fault=%b data=%02h, want %b 0 %02h",
                 i, ad, st, wr, a_valid, a_fault, a_dout, st, exp_d);
      end
    end
    a_strobe = 1'b0;
  endtask

  task automatic test_no_clear_reset;
    b_reset = 1'b1; b_strobe = 1'b1; b_write = 1'b1; b_addr = 12'h805; b_din = 8'h99;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (b_valid !== 1'b0 || b_dout !== 8'h00 || b_busy !== 1'b0 || b_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_with_strobe[%0d]: got valid=%b data=%02h busy=%b fault=%b, want 0 00 0 0",
                 i, b_valid, b_dout, b_busy, b_fault);
      end
    end
    b_reset = 1'b0; b_strobe = 1'b0;
    tick();
    vectors++;
    if (b_ready !== 1'b1 || b_busy !== 1'b0 || b_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_no_fill: got ready=%b busy=%b valid=%b, want 1 0 0", b_ready, b_busy, b_valid);
    end
    b_strobe = 1'b1; b_write = 1'b1; b_din = 8'h33;
    tick();
    vectors++;
    if (b_valid !== 1'b1 || b_dout !== 8'h33) begin
      miscompares++;
      $display("FAIL ram_write_b: got valid=%b data=%02h, want 1 33", b_valid, b_dout);
    end
    b_reset = 1'b1; b_din = 8'h99;
    tick();
    vectors++;
    if (b_valid !== 1'b0 || b_dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_beats_strobe: got valid=%b data=%02h, want 0 00", b_valid, b_dout);
    end
    b_reset = 1'b0; b_write = 1'b0;
    tick();
    vectors++;
    if (b_valid !== 1'b1 || b_dout !== 8'h33) begin
      miscompares++;
      $display("FAIL dropped_write: got valid=%b data=%02h, want 1 33", b_valid, b_dout);
    end
    b_strobe = 1'b0;
    model_b[12'h805] = 8'h33;
  endtask

  task automatic test_rom;
    b_strobe = 1'b1; b_write = 1'b1; b_addr = 12'h010; b_din = 8'hFF;
    tick();
    vectors++;
    if (b_valid !== 1'b1 || b_fault !== 1'b1 || b_dout !== 8'hA7) begin
      miscompares++;
      $display("FAIL rom_write: got valid=%b fault=%b data=%02h, want 1 1 a7", b_valid, b_fault, b_dout);
    end
    b_strobe = 1'b0;
    tick();
    vectors++;
    if (b_valid !== 1'b0 || b_fault !== 1'b0 || b_dout !== 8'hA7) begin
      miscompares++;
      $display("FAIL rom_fault_pulse: got valid=%b fault=%b data=%02h, want 0 0 a7", b_valid, b_fault, b_dout);
    end
    b_strobe = 1'b1; b_write = 1'b0;
    tick();
    vectors++;
    if (b_valid !== 1'b1 || b_fault !== 1'b0 || b_dout !== 8'hA7) begin
      miscompares++;
      $display("FAIL rom_readback: got valid=%b fault=%b data=%02h, want 1 0 a7", b_valid, b_fault, b_dout);
    end
    b_strobe = 1'b0;
  endtask

  task automatic test_random_b;
    logic [AW_B-1:0] ad;
    logic [7:0]      d, exp_d;
    logic            st, wr, rom, exp_f;
    int              bad_init;
    bad_init = 0;
    for (int i = 0; i < 64; i++) begin
      ad = {1'b1, 5'd0, 6'(i)};
      d  = 8'($urandom);
      b_strobe = 1'b1; b_write = 1'b1; b_addr = ad; b_din = d;
      tick();
      model_b[ad] = d;
      if (b_valid !== 1'b1 || b_fault !== 1'b0 || b_dout !== d) bad_init++;
    end
    vectors++;
    if (bad_init != 0) begin
      miscompares++;
      $display("FAIL init_bank1: got %0d bad writes, want 0", bad_init);
    end
    exp_d = model_b[{1'b1, 5'd0, 6'd63}];
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 3) != 0);
      wr  = 1'($urandom);
      ad  = {1'($urandom), 5'd0, 6'($urandom)};
      rom = (ad[AW_B-1] == 1'b0);
      d   = 8'($urandom);
      b_strobe = st; b_write = wr; b_addr = ad; b_din = d;
      tick();
      exp_f = st && wr && rom;
      if (st) begin
        if (wr && !rom) model_b[ad] = d;
        exp_d = model_b[ad];
      end
      vectors++;
      if (b_valid !== st || b_fault !== exp_f || b_dout !== exp_d) begin
        miscompares++;
        $display("FAIL random_b[%0d] addr=%h st=%b wr=%b: got valid=%b fault=%b data=%02h, want %b %b %02h",
                 i, ad, st, wr, b_valid, b_fault, b_dout, st, exp_f, exp_d);
      end
    end
    b_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    a_reset = 1'b1; a_write = 1'b0; a_strobe = 1'b0; a_addr = '0; a_din = '0;
    b_reset = 1'b1; b_write = 1'b0; b_strobe = 1'b0; b_addr = '0; b_din = '0;
    // Read-only bank 0 of the second instance is loaded directly, as the program image would be.
    for (int i = 0; i < 64; i++) begin
      v = (i == 16) ? 8'hA7 : 8'($urandom);
      dut_b.g_bank[0].mem_q[i] = v;
      model_b[i] = v;
    end
    test_reset();
    test_read_zero();
    test_write_read();
    test_back_to_back();
    test_random_a();
    test_no_clear_reset();
    test_rom();
    test_random_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
